// File: rtl/lpc_pkg.sv
// Shared constants and types for the LPC analysis front end.
package lpc_pkg;

  localparam int unsigned FRAME_LEN = 160;
  localparam int unsigned SAMPLE_W  = 16;
  localparam int unsigned N_LAGS    = 11;

  // Frame writer states: filling the write bank, or handing a full bank over.
  typedef enum logic {
    FILL = 1'b0,
    SWAP = 1'b1
  } wr_state_t;

endpackage

// File: rtl/lpc_frame_writer.sv
// Write side of the LPC ping-pong frame buffer: streams samples into the
// write bank, hands full banks to the autocorrelation reader, and stalls
// input while both banks are occupied.
module lpc_frame_writer
  import lpc_pkg::*;
#(
  parameter int unsigned FRAME_LEN = lpc_pkg::FRAME_LEN,
  parameter int unsigned DATA_W    = lpc_pkg::SAMPLE_W,
  parameter int unsigned ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              wen,
  output logic [ADDR_W:0]   waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              rbank,
  output logic              ac_start,
  input  logic              ac_ready,
  output logic              stall
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

  wr_state_t         r_state;
  wr_state_t         w_state_nxt;
  logic [ADDR_W-1:0] r_wcnt;
  logic [ADDR_W-1:0] w_wcnt_nxt;
  logic              r_wbank;
  logic              r_ac_busy;
  logic              r_start_d;
  logic              w_accept;

  assign w_accept = in_valid & in_ready;
  assign wen      = w_accept;
  assign waddr    = {r_wbank, r_wcnt};
  assign wdata    = in_data;
  assign rbank    = ~r_wbank;

  // Next-state and handshake/control decode; everything held low during reset.
  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    in_ready    = 1'b0;
    ac_start    = 1'b0;
    stall       = 1'b0;
    if (reset) begin
      case (r_state)
        FILL: begin
          in_ready = 1'b1;
          if (in_valid) begin
            if (r_wcnt == LAST_IDX) begin
              w_wcnt_nxt  = '0;
              w_state_nxt = SWAP;
            end else begin
              w_wcnt_nxt = r_wcnt + 1'b1;
            end
          end
        end
        SWAP: begin
          if (!r_ac_busy) begin
            ac_start    = 1'b1;
            w_state_nxt = FILL;
          end else begin
            stall = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // State, counter, bank and busy tracking. The reader's ready is stale on the
  // start cycle and the cycle after it, so it is ignored while either is high;
  // setting busy on a start wins over any clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= FILL;
      r_wcnt    <= '0;
      r_wbank   <= 1'b0;
      r_ac_busy <= 1'b0;
      r_start_d <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_wcnt    <= w_wcnt_nxt;
      r_start_d <= ac_start;
      if (ac_start) begin
        r_wbank   <= ~r_wbank;
        r_ac_busy <= 1'b1;
      end else if (r_ac_busy && ac_ready && !r_start_d) begin
        r_ac_busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lpc_frame_writer.sv
// Self-checking bench for lpc_frame_writer: a frame-level reference model
// checked every cycle, a table of directed vectors, and directed/random
// sequences for handoff, stall, stale-ready and reset corner cases.
module tb_lpc_frame_writer;

  localparam int FLEN = 160;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        wen;
  logic [8:0]  waddr;
  logic [15:0] wdata;
  logic        rbank;
  logic        ac_start;
  logic        ac_ready;
  logic        stall;

  lpc_frame_writer #(.FRAME_LEN(160), .DATA_W(16), .ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .wen(wen), .waddr(waddr), .wdata(wdata),
    .rbank(rbank), .ac_start(ac_start), .ac_ready(ac_ready), .stall(stall)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: samples held in the open frame, whether a full frame is
  // waiting for handoff, which bank is being written, whether the reader is
  // running, and how many cycles have passed since the last reader start.
  int m_n     = 0;
  bit m_full  = 0;
  bit m_wbank = 0;
  bit m_busy  = 0;
  int m_since = 100;
  bit m_valid = 0;

  // Last observed DUT outputs and event counters.
  bit         l_ir, l_wen, l_ast, l_stall, l_rbank;
  logic [8:0] l_waddr;
  int         ast_count = 0;
  int         wr_count  = 0;

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic cyc(input bit rst, input bit v, input logic [15:0] d, input bit rdy);
    bit e_ir, e_wen, e_ast, e_stl, e_rb;
    logic [8:0] e_waddr;
    logic [29:0] got, exp;
    @(negedge clk);
    reset = rst; in_valid = v; in_data = d; ac_ready = rdy;
    #1;
    e_ir    = rst && !m_full;
    e_wen   = v && e_ir;
    e_ast   = rst && m_full && !m_busy;
    e_stl   = rst && m_full && m_busy;
    e_rb    = !m_wbank;
    e_waddr = {m_wbank, 8'(m_n)};
    if (m_valid) begin
      got = {in_ready, wen, waddr, wdata, rbank, ac_start, stall};
      exp = {e_ir, e_wen, e_waddr, d, e_rb, e_ast, e_stl};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL cycle@%0t: got ir=%b wen=%b waddr=%h wdata=%h rbank=%b start=%b stall=%b expected ir=%b wen=%b waddr=%h wdata=%h rbank=%b start=%b stall=%b",
                 $time, in_ready, wen, waddr, wdata, rbank, ac_start, stall,
                 e_ir, e_wen, e_waddr, d, e_rb, e_ast, e_stl);
      end
    end
    l_ir = in_ready; l_wen = wen; l_ast = ac_start; l_stall = stall;
    l_rbank = rbank; l_waddr = waddr;
    if (wen) wr_count++;
    if (ac_start) ast_count++;
    @(posedge clk);
    if (!rst) begin
      m_n = 0; m_full = 0; m_wbank = 0; m_busy = 0; m_since = 100; m_valid = 1;
    end else begin
      if (e_wen) begin
        if (m_n == FLEN - 1) begin m_n = 0; m_full = 1; end
        else m_n++;
      end
      if (e_ast) begin
        m_wbank = !m_wbank; m_full = 0; m_busy = 1; m_since = 1;
      end else begin
        if (m_busy && rdy && m_since >= 2) m_busy = 0;
        if (m_since < 100) m_since++;
      end
    end
  endtask

  typedef struct {
    bit rst; bit v; logic [15:0] d; bit rdy;
    bit e_ir; bit e_wen; logic [8:0] e_waddr; bit e_ast; bit e_stl;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int a0, w0, fw;
    reset = 0; in_valid = 0; in_data = '0; ac_ready = 0;

    // Directed vectors right after reset, ending with a one-sample restart.
    tbl[0] = '{1, 0, 16'h0000, 0, 1, 0, 9'h000, 0, 0};
    tbl[1] = '{1, 1, 16'h0000, 0, 1, 1, 9'h000, 0, 0};
    tbl[2] = '{1, 1, 16'h0001, 0, 1, 1, 9'h001, 0, 0};
    tbl[3] = '{0, 1, 16'h0002, 0, 0, 0, 9'h002, 0, 0};
    tbl[4] = '{1, 1, 16'h0000, 0, 1, 1, 9'h000, 0, 0};

    // Test 1: reset 3 cycles, then frame 0..159.
    for (int i = 0; i < 3; i++) cyc(0, 1, 16'hFFFF, 0);
    check("reset_in_ready", l_ir, 0);
    check("reset_rbank", l_rbank, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(tbl[i].rst, tbl[i].v, tbl[i].d, tbl[i].rdy);
      check("tbl_in_ready", l_ir, tbl[i].e_ir);
      check("tbl_wen", l_wen, tbl[i].e_wen);
      check("tbl_waddr", l_waddr, tbl[i].e_waddr);
      check("tbl_ac_start", l_ast, tbl[i].e_ast);
      check("tbl_stall", l_stall, tbl[i].e_stl);
    end
    w0 = wr_count;
    for (int i = 1; i < FLEN; i++) begin
      cyc(1, 1, 16'(i), 0);
      if (i == FLEN - 1) check("t1_last_waddr", l_waddr, 9'h09F);
    end
    check("t1_write_count", wr_count - w0 + 1, 160);
    cyc(1, 1, 16'h5555, 0);
    check("t1_swap_in_ready", l_ir, 0);
    check("t1_swap_ac_start", l_ast, 1);
    cyc(1, 1, 16'h0000, 0);
    check("t1_rbank", l_rbank, 0);
    check("t1_in_ready", l_ir, 1);
    check("t1_waddr_bank1", l_waddr, 9'h100);

    // Test 2: second frame with reader busy -> indefinite stall.
    for (int i = 1; i < FLEN; i++) cyc(1, 1, 16'(i), 0);
    check("t2_last_waddr", l_waddr, 9'h19F);
    a0 = ast_count;
    for (int i = 0; i < 20; i++) cyc(1, 1, 16'hAAAA, 0);
    check("t2_stall", l_stall, 1);
    check("t2_stall_in_ready", l_ir, 0);
    check("t2_no_start", ast_count - a0, 0);
    cyc(1, 1, 16'hAAAA, 1);
    check("t2_ready_cycle_start", l_ast, 0);
    // Test 3 begins: ready held high (stale) over the start cycle and the next.
    cyc(1, 1, 16'hAAAA, 1);
    check("t2_start_after_ready", l_ast, 1);
    cyc(1, 1, 16'h0000, 1);
    check("t2_rbank", l_rbank, 1);
    check("t2_next_waddr", l_waddr, 9'h000);
    a0 = ast_count;
    for (int i = 1; i <= 1760; i++) cyc(1, 1, 16'(i), 0);
    check("t3_no_start_stale", ast_count - a0, 0);
    check("t3_stalled", l_stall, 1);
    cyc(1, 1, 16'h0, 1);
    cyc(1, 1, 16'h0, 0);
    check("t3_start_after_rise", l_ast, 1);

    // Test 6: ready rises on the cycle the 160th sample is accepted.
    for (int i = 0; i < FLEN - 1; i++) cyc(1, 1, 16'($urandom), 0);
    cyc(1, 1, 16'($urandom), 1);
    check("t6_last_wen", l_wen, 1);
    cyc(1, 1, 16'h0, 0);
    check("t6_start", l_ast, 1);
    check("t6_no_stall", l_stall, 0);
    cyc(1, 1, 16'h0, 0);
    check("t6_in_ready", l_ir, 1);

    // Test 4: random 30% valid, random ready; 160 writes between handoffs.
    a0 = ast_count;
    fw = wr_count - 1;
    for (int c = 0; c < 20000 && ast_count - a0 < 3; c++) begin
      cyc(1, ($urandom % 100) < 30, 16'($urandom), ($urandom % 4) == 0);
      if (l_ast) begin
        check("t4_frame_writes", wr_count - fw, 160);
        fw = wr_count;
      end
    end
    check("t4_frames_done", ast_count - a0, 3);

    // Test 5: reset mid-frame at wcnt=75 with reader still busy.
    for (int c = 0; c < 400 && !(l_ir && m_n == 75); c++) cyc(1, 0, 16'h0, 0);
    for (int i = 0; i < 75; i++) cyc(1, 1, 16'(i), 0);
    cyc(0, 1, 16'h1234, 0);
    check("t5_reset_in_ready", l_ir, 0);
    cyc(0, 1, 16'h1234, 0);
    check("t5_reset_in_ready2", l_ir, 0);
    cyc(1, 1, 16'h0000, 0);
    check("t5_first_waddr", l_waddr, 9'h000);
    check("t5_first_wen", l_wen, 1);
    check("t5_rbank", l_rbank, 1);
    for (int i = 1; i < FLEN; i++) cyc(1, 1, 16'(i), 0);
    cyc(1, 1, 16'h0, 0);
    check("t5_start_no_wait", l_ast, 1);
    cyc(1, 0, 16'h0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lpc_frame_writer.md
Name: lpc_frame_writer

Overview:
- Write side of the LPC analysis frame buffer. Accepts the incoming sample stream over a valid/ready handshake and writes each 160-sample frame into a ping-pong RAM, 2 banks x 160 words.
- When a frame is complete, it hands that bank to the autocorrelation controller, which reads addresses 0..159 per lag. It restarts the controller with a one-cycle start pulse, tracks completion through the controller's ready, and stalls input when both banks are occupied.

Parameters:
- FRAME_LEN, 160, samples per frame; the controller read address runs 0..FRAME_LEN-1.
- DATA_W, 16, sample width in bits.
- ADDR_W, 8, in-bank address width; must satisfy 2^ADDR_W >= FRAME_LEN.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low: reset==0 sampled at a rising edge resets the block.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample this cycle.
- in_data  in  DATA_W  input sample.
- wen  out  1  RAM write enable.
- waddr  out  ADDR_W+1  RAM write address: {wbank, wcnt}.
- wdata  out  DATA_W  RAM write data.
- rbank  out  1  bank owned by the autocorrelation reader. The controller read address is {rbank, raddr}.
- ac_start  out  1  one-cycle pulse. Drives the autocorrelation controller's (active-high) reset, which restarts it at lag 0, sample 0.
- ac_ready  in  1  autocorrelation controller ready: all 11 lags finished.
- stall  out  1  a full frame is waiting for the reader (state SWAP with ac_busy=1).

Behaviour:
- Internal registers:
  - state: FILL or SWAP.
  - wcnt: ADDR_W bits, 0..FRAME_LEN-1.
  - wbank: 1 bit.
  - ac_busy: 1 bit.
  - start_d: 1 bit, ac_start delayed one cycle.
- Reset (reset==0 at an edge): state=FILL, wcnt=0, wbank=0, ac_busy=0, start_d=0.
- While reset is low, combinational outputs are forced: in_ready=0, wen=0, ac_start=0, stall=0. rbank=1 after reset.
- rbank = ~wbank at all times; the reader and writer never share a bank.
- accept = in_valid && in_ready.
  - wen = accept; waddr = {wbank, wcnt}; wdata = in_data.
  - All three are combinational in the same cycle, so the RAM writes at that edge. Zero latency.
- FILL:
  - in_ready=1.
  - On accept with wcnt<FRAME_LEN-1: wcnt+1.
  - On accept with wcnt==FRAME_LEN-1: wcnt=0, next state SWAP.
  - With no accept, hold.
- SWAP:
  - in_ready=0 (exactly one bubble per frame even when the reader is idle).
  - If ac_busy==0:
    - ac_start=1 this cycle.
    - At the edge: wbank toggles, ac_busy=1, state=FILL.
  - Else: hold in SWAP, stall=1, ac_start=0.
- ac_busy clear rule: ac_busy is cleared at the edge where ac_busy && ac_ready && !start_d && !ac_start.
  - Reason: the controller's ready is stale on the ac_start cycle and the cycle after it, so it is ignored for those 2 cycles.
  - The set of ac_busy (from ac_start) has priority over the clear.
- start_d <= ac_start each cycle.
- Simultaneous events: in SWAP, if the clear condition holds in cycle N, ac_start asserts in cycle N+1 (registered busy; no combinational ac_ready -> ac_start path).
- Reset mid-frame: the partial frame is discarded; the next accepted sample writes {0, 0}. A controller run in progress is not aborted by this block, but ac_busy=0 means the next frame restarts it via ac_start.
- First frame after reset starts the controller immediately, since ac_busy=0.
- in_data is not modified; no arithmetic beyond the wcnt increment, which has no wrap past FRAME_LEN-1.

Decomposition:
- Shared package lpc_pkg holds:
  - FRAME_LEN=160, SAMPLE_W=16, N_LAGS=11.
  - The writer state typedef (FILL, SWAP).
- The autocorrelation controller should take FRAME_LEN from the same package.
- No sub-module: counter, FSM and busy tracker fit in one flat module.

Test Plan:
1. Reset low 3 cycles, then high; drive 160 samples 0..159 with in_valid=1 continuously -> wen on 160 consecutive cycles, waddr 0x000..0x09F; next cycle in_ready=0, ac_start=1; cycle after: rbank=0, wbank=1, in_ready=1.
2. Continue streaming a second frame with ac_ready held 0 -> writes to 0x100..0x19F; then stall=1, in_ready=0 indefinitely, no ac_start. Raise ac_ready -> ac_start 1 cycle later; rbank=1, next write at 0x000.
3. ac_ready=1 (stale) during the ac_start cycle and the following cycle, then 0 for 1760 cycles, then 1 -> ac_busy stays 1 through the stale window and clears only after the final rise.
4. in_valid toggled randomly at 30% -> exactly 160 writes per frame, addresses contiguous, no write while in_ready=0.
5. Assert reset at wcnt=75 of frame 2 -> in_ready=0 during reset; after release the first write is at waddr 0x000 and rbank=1; the next completed frame pulses ac_start without waiting for ac_ready.
6. ac_ready rises in the same cycle the 160th sample is accepted -> SWAP lasts 1 cycle with ac_start=1; no stall observed.
